mxu_row_packer: RTL

Downstream of the RAM buffer, feeding the MXU. Takes the RAM buffer's per-cycle byte-masked output (`ram_buff_mxu_vld` and `ram_buff_mxu_data`) and compacts the valid bytes into dense 16-byte rows. Rows go to the MXU over a valid/ready handshake. Backpressure goes upstream through an almost-full flag, and a flush command closes out a partial final row.

---
 rtl/mxu_row_packer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mxu_row_packer.sv
// Packs byte-masked beats from the RAM buffer into dense 16-byte rows for the MXU.
// Optional macro MXU_PACK_ZERO_PAD_EN: zero the bytes above byte_cnt in partial rows.
module mxu_row_packer #(
    parameter int DATA_WIDTH = 128,
    parameter int ACC_BYTES  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH/8-1:0] ram_buff_mxu_vld,
    input  logic [DATA_WIDTH-1:0]   ram_buff_mxu_data,
    input  logic                    ctrl_pack_flush,
    input  logic                    ctrl_pack_clr,
    input  logic                    mxu_pack_rdy,
    output logic                    pack_mxu_vld,
    output logic [DATA_WIDTH-1:0]   pack_mxu_data,
    output logic [4:0]              pack_mxu_byte_cnt,
    output logic                    pack_mxu_last,
    output logic                    pack_afull,
    output logic                    pack_ovf
);
    localparam int ROW_BYTES = DATA_WIDTH / 8;
    localparam int ACC_W     = ACC_BYTES * 8;
    localparam logic [5:0] ROW_CNT = 6'd16;
    localparam logic [6:0] ACC_CAP = 7'd32;

    logic [ACC_W-1:0]      r_acc_data;
    logic [5:0]            r_acc_cnt;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [4:0]            r_out_cnt;
    logic                  r_out_last;
    logic                  r_out_vld;
    logic                  r_flush_pend;
    logic                  r_ovf;
    logic                  r_afull;

    logic [DATA_WIDTH-1:0] w_comp;
    logic [4:0]            w_k;
    logic                  w_beat;
    logic                  w_out_free;
    logic                  w_drain;
    logic [5:0]            w_drained;
    logic [5:0]            w_rem;
    logic                  w_ovf_now;
    logic                  w_take;
    logic                  w_last;
    logic [5:0]            w_acc_cnt_next;
    logic [ACC_W-1:0]      w_shifted;
    logic [ACC_W-1:0]      w_ins;
    logic [ACC_W-1:0]      w_acc_next;
    logic [DATA_WIDTH-1:0] w_row;
    logic                  w_flush_pend_next;

    // Gather valid lanes, lowest lane first, into the bottom k bytes.
    always_comb begin
        int idx;
        w_comp = '0;
        idx    = 0;
        for (int i = 0; i < ROW_BYTES; i++) begin
            if (ram_buff_mxu_vld[i]) begin
                w_comp[idx*8 +: 8] = ram_buff_mxu_data[i*8 +: 8];
                idx = idx + 1;
            end
        end
        w_k = idx[4:0];
    end

    assign w_beat     = |ram_buff_mxu_vld;
    assign w_out_free = !r_out_vld || mxu_pack_rdy;
    assign w_drain    = w_out_free &&
                        ((r_acc_cnt >= ROW_CNT) || (r_flush_pend && (r_acc_cnt != 6'd0)));
    assign w_drained  = !w_drain ? 6'd0 : ((r_acc_cnt >= ROW_CNT) ? ROW_CNT : r_acc_cnt);
    assign w_rem      = r_acc_cnt - w_drained;
    assign w_ovf_now  = w_beat && (({1'b0, w_rem} + {2'b00, w_k}) > ACC_CAP);
    assign w_take     = w_beat && !w_ovf_now;
    assign w_last     = r_flush_pend && w_drain && (w_rem == 6'd0) && !w_take;
    assign w_acc_cnt_next = w_take ? (w_rem + {1'b0, w_k}) : w_rem;

    // New bytes land directly above what survives the drain.
    assign w_shifted = r_acc_data >> {w_drained, 3'b000};
    assign w_ins     = {{(ACC_W-DATA_WIDTH){1'b0}}, w_comp} << {w_rem, 3'b000};

    for (genvar gi = 0; gi < ACC_BYTES; gi++) begin : g_acc
        assign w_acc_next[gi*8 +: 8] = ((6'(gi) < w_rem) || !w_take) ?
                                       w_shifted[gi*8 +: 8] : w_ins[gi*8 +: 8];
    end

    for (genvar gi = 0; gi < ROW_BYTES; gi++) begin : g_row
`ifdef MXU_PACK_ZERO_PAD_EN
        assign w_row[gi*8 +: 8] = (6'(gi) < w_drained) ? r_acc_data[gi*8 +: 8] : 8'h00;
`else
        assign w_row[gi*8 +: 8] = r_acc_data[gi*8 +: 8];
`endif
    end

    // A flush against an empty accumulator with no beat completes on the spot.
    always_comb begin
        w_flush_pend_next = r_flush_pend;
        if (w_last) begin
            w_flush_pend_next = 1'b0;
        end else if (ctrl_pack_flush && ((r_acc_cnt != 6'd0) || w_take)) begin
            w_flush_pend_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_data   <= '0;
            r_acc_cnt    <= '0;
            r_out_data   <= '0;
            r_out_cnt    <= '0;
            r_out_last   <= 1'b0;
            r_out_vld    <= 1'b0;
            r_flush_pend <= 1'b0;
            r_ovf        <= 1'b0;
            r_afull      <= 1'b0;
        end else if (ctrl_pack_clr) begin
            r_acc_cnt    <= '0;
            r_out_vld    <= 1'b0;
            r_flush_pend <= 1'b0;
            r_ovf        <= 1'b0;
            r_afull      <= 1'b0;
        end else begin
            r_acc_data   <= w_acc_next;
            r_acc_cnt    <= w_acc_cnt_next;
            r_flush_pend <= w_flush_pend_next;
            r_afull      <= (w_acc_cnt_next > ROW_CNT);
            if (w_ovf_now) begin
                r_ovf <= 1'b1;
            end
            if (w_drain) begin
                r_out_data <= w_row;
                r_out_cnt  <= w_drained[4:0];
                r_out_last <= w_last;
                r_out_vld  <= 1'b1;
            end else if (r_out_vld && mxu_pack_rdy) begin
                r_out_vld  <= 1'b0;
            end
        end
    end

    assign pack_mxu_vld      = r_out_vld;
    assign pack_mxu_data     = r_out_data;
    assign pack_mxu_byte_cnt = r_out_cnt;
    assign pack_mxu_last     = r_out_last;
    assign pack_afull        = r_afull;
    assign pack_ovf          = r_ovf;
endmodule
